gf2_mul_arbiter: RTL and testbench
==================================

Name: gf2_mul_arbiter

Overview:
Round-robin arbiter and sequencer that shares one sequential GF(2) polynomial multiplier core (start/done interface, e.g. a 284-bit Toom-4 core) between N_REQ requesters. It accepts one operand pair at a time over a valid/ready handshake, issues the job to the core, and waits for completion. It then returns the 2*OP_W-bit product to the granted requester over a valid/ready response channel. It sits between the protocol-level clients and the multiplier datapath.

Parameters:
N_REQ, 2, number of requesters (2..8)
OP_W, 284, operand width in bits; result width RES_W = 2*OP_W (localparam)
TIMEOUT_CYC, 1024, watchdog limit in cycles (used only with GF2ARB_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  N_REQ  per-requester job valid
req_ready  output  N_REQ  per-requester accept; one-hot or zero
req_a  input  N_REQ*OP_W  operand A per requester; requester i at [i*OP_W +: OP_W]
req_b  input  N_REQ*OP_W  operand B per requester; same packing
rsp_valid  output  N_REQ  per-requester result valid; one-hot or zero
rsp_ready  input  N_REQ  per-requester result accept
rsp_data  output  RES_W  shared result bus; meaningful only where rsp_valid is set
rsp_err  output  1  result is a timeout error; constant 0 without GF2ARB_TIMEOUT_EN
mul_start  output  1  one-cycle start pulse to the core
mul_a  output  OP_W  registered operand A to the core; held stable from ISSUE through end of WAIT
mul_b  output  OP_W  registered operand B to the core; same rule
mul_done  input  1  one-cycle completion pulse from the core
mul_w  input  RES_W  core product; valid in the mul_done cycle
busy  output  1  high in any state other than IDLE
grant_id  output  3  index of the current or last granted requester

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- Reset values:
  - All outputs are 0: req_ready, rsp_valid, rsp_data, rsp_err, mul_start, mul_a, mul_b, busy, grant_id.
  - Internal last_grant = N_REQ-1, so requester 0 wins first.
- IDLE:
  - Arbitration is combinational over req_valid, round-robin, starting at last_grant+1 with wrap-around modulo N_REQ.
  - req_ready[g] is asserted for the winner only; no other requester sees ready.
  - On the handshake (req_valid[g] & req_ready[g]): latch req_a/req_b slice g into mul_a/mul_b, set grant_id = last_grant = g, go to ISSUE.
  - With no valid request, the block stays in IDLE and req_ready = 0.
- ISSUE: mul_start = 1 for exactly one cycle; go to WAIT unconditionally.
- WAIT: on mul_done, register mul_w into rsp_data, set rsp_err = 0, go to RESP.
- RESP:
  - rsp_valid[g] = 1, held with rsp_data stable until rsp_ready[g].
  - In the handshake cycle, go to IDLE; rsp_valid drops on the next edge.
- mul_done is ignored in IDLE, ISSUE and RESP. A spurious pulse must not alter state or data.
- Latency: accept at cycle T, mul_start at T+1, rsp_valid at D+1 where D is the mul_done cycle. The fastest re-accept is the cycle after the response handshake.
- Fairness: under continuous requests from all requesters, grants rotate 0,1,...,N_REQ-1,0. No requester waits more than N_REQ-1 jobs.
- rsp_ready on a non-granted index has no effect. req_valid deasserting before acceptance is legal (no commitment).
- Reset mid-operation: any state returns to IDLE immediately and any pending response is dropped. Resetting the core is the system's responsibility; a late mul_done after reset is ignored.

Optional Feature:
GF2ARB_TIMEOUT_EN
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYC without mul_done: go to RESP with rsp_data = 0 and rsp_err = 1.
  - rsp_err clears when the RESP handshake completes.
  - The counter is sized $clog2(TIMEOUT_CYC+1).
- Undefined: no counter is built, rsp_err is tied to 0, and WAIT waits indefinitely.

Test Plan:
Bench uses a core model that returns the carry-less product (bit0 = x^0) after a fixed 6-cycle latency.
- Single job: requester 0 sends a=0x1, b=0x3 -> mul_start exactly once at T+1; rsp_valid[0] at T+8 with rsp_data=0x3; busy high from T+1 until the cycle after the response handshake.
- Round-robin: both requesters held valid for 4 jobs (a=0x5, b=0x7 from each) -> grant order 0,1,0,1; every rsp_data=0x1B.
- Response backpressure: rsp_ready[0] held low 10 cycles -> rsp_valid/rsp_data stable, req_ready stays 0 for requester 1, no new mul_start.
- Spurious done: pulse mul_done in IDLE and in RESP -> no state change, rsp_data unchanged.
- Reset mid-WAIT: assert reset 3 cycles after mul_start -> all outputs 0 at once; a late mul_done produces no rsp_valid; next job grants requester 0.
- GF2ARB_TIMEOUT_EN with TIMEOUT_CYC=16 and the model never returning done -> rsp_valid with rsp_err=1 and rsp_data=0 exactly 16 WAIT cycles after entering WAIT.

Source files
------------

// File: rtl/gf2_mul_arbiter.sv
// Round-robin front end sharing one sequential GF(2) multiplier core.
// Optional watchdog: define GF2ARB_TIMEOUT_EN.
module gf2_mul_arbiter #(
   parameter int N_REQ       = 2,
   parameter int OP_W        = 284,
   parameter int TIMEOUT_CYC = 1024,
   localparam int RES_W      = 2 * OP_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_REQ-1:0]      req_valid,
   output logic [N_REQ-1:0]      req_ready,
   input  logic [N_REQ*OP_W-1:0] req_a,
   input  logic [N_REQ*OP_W-1:0] req_b,
   output logic [N_REQ-1:0]      rsp_valid,
   input  logic [N_REQ-1:0]      rsp_ready,
   output logic [RES_W-1:0]      rsp_data,
   output logic                  rsp_err,
   output logic                  mul_start,
   output logic [OP_W-1:0]       mul_a,
   output logic [OP_W-1:0]       mul_b,
   input  logic                  mul_done,
   input  logic [RES_W-1:0]      mul_w,
   output logic                  busy,
   output logic [2:0]            grant_id
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t          state;
   logic [2:0]      last_grant;
   logic [2:0]      win_idx;
   logic            win_found;
   logic            accept;
   logic            rsp_hs;
   logic [OP_W-1:0] sel_a;
   logic [OP_W-1:0] sel_b;
   int              idx;

   // First valid requester at or after last_grant+1, wrapping.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      idx       = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (int'(last_grant) + k) % N_REQ;
         for (int i = 0; i < N_REQ; i++) begin
            if (!win_found && i == idx && req_valid[i]) begin
               win_found = 1'b1;
               win_idx   = 3'(i);
            end
         end
      end
   end

   always_comb begin
      sel_a     = '0;
      sel_b     = '0;
      req_ready = '0;
      rsp_valid = '0;
      rsp_hs    = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (i == int'(win_idx)) begin
            sel_a        = req_a[i*OP_W +: OP_W];
            sel_b        = req_b[i*OP_W +: OP_W];
            req_ready[i] = (state == IDLE) && !reset && win_found;
         end
         if (i == int'(grant_id)) begin
            rsp_valid[i] = (state == RESP);
            rsp_hs       = (state == RESP) && rsp_ready[i];
         end
      end
   end

   assign accept = |req_ready;
   assign busy   = (state != IDLE);

`ifdef GF2ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] wait_cnt;
`else
   assign rsp_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= 3'(N_REQ - 1);
         grant_id   <= '0;
         mul_start  <= 1'b0;
         mul_a      <= '0;
         mul_b      <= '0;
         rsp_data   <= '0;
`ifdef GF2ARB_TIMEOUT_EN
         rsp_err    <= 1'b0;
         wait_cnt   <= '0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  mul_a      <= sel_a;
                  mul_b      <= sel_b;
                  grant_id   <= win_idx;
                  last_grant <= win_idx;
                  mul_start  <= 1'b1;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               mul_start <= 1'b0;
`ifdef GF2ARB_TIMEOUT_EN
               wait_cnt  <= '0;
`endif
               state     <= WAIT;
            end
            WAIT: begin
               if (mul_done) begin
                  rsp_data <= mul_w;
`ifdef GF2ARB_TIMEOUT_EN
                  rsp_err  <= 1'b0;
`endif
                  state    <= RESP;
`ifdef GF2ARB_TIMEOUT_EN
               // Count value k marks the (k+1)-th WAIT cycle.
               end else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                  rsp_data <= '0;
                  rsp_err  <= 1'b1;
                  state    <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
`endif
               end
            end
            RESP: begin
               if (rsp_hs) begin
`ifdef GF2ARB_TIMEOUT_EN
                  rsp_err <= 1'b0;
`endif
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gf2_mul_arbiter.sv
// Directed bench for gf2_mul_arbiter with a 6-cycle carry-less core model.
module tb_gf2_mul_arbiter;

   localparam int N_REQ = 2;
   localparam int OP_W  = 284;
   localparam int RES_W = 2 * OP_W;
`ifdef GF2ARB_TIMEOUT_EN
   localparam int TO_CYC = 16;
`else
   localparam int TO_CYC = 1024;
`endif

   logic                  clk = 1'b0;
   logic                  reset;
   logic [N_REQ-1:0]      req_valid;
   logic [N_REQ-1:0]      req_ready;
   logic [N_REQ*OP_W-1:0] req_a;
   logic [N_REQ*OP_W-1:0] req_b;
   logic [N_REQ-1:0]      rsp_valid;
   logic [N_REQ-1:0]      rsp_ready;
   logic [RES_W-1:0]      rsp_data;
   logic                  rsp_err;
   logic                  mul_start;
   logic [OP_W-1:0]       mul_a;
   logic [OP_W-1:0]       mul_b;
   logic                  mul_done;
   logic [RES_W-1:0]      mul_w;
   logic                  busy;
   logic [2:0]            grant_id;

   logic                  model_en;
   logic                  model_done;
   logic                  spur;
   logic [3:0]            mcnt;
   logic [OP_W-1:0]       ma;
   logic [OP_W-1:0]       mb;

   int tests = 0;
   int fails = 0;

   gf2_mul_arbiter #(
      .N_REQ(N_REQ), .OP_W(OP_W), .TIMEOUT_CYC(TO_CYC)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err),
      .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
      .mul_done(mul_done), .mul_w(mul_w),
      .busy(busy), .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   function automatic logic [RES_W-1:0] clmul(input logic [OP_W-1:0] a,
                                              input logic [OP_W-1:0] b);
      logic [RES_W-1:0] r;
      r = '0;
      for (int i = 0; i < OP_W; i++)
         if (b[i]) r = r ^ (RES_W'(a) << i);
      return r;
   endfunction

   // Core model: done 6 cycles after the start cycle; ignores reset.
   always @(posedge clk) begin
      model_done <= 1'b0;
      if (mul_start && model_en) begin
         mcnt <= 4'd5;
         ma   <= mul_a;
         mb   <= mul_b;
      end else if (mcnt != 0) begin
         mcnt <= mcnt - 1'b1;
         if (mcnt == 4'd1) begin
            model_done <= 1'b1;
            mul_w      <= clmul(ma, mb);
         end
      end
   end

   assign mul_done = model_done | spur;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic set_ops(input int r, input logic [OP_W-1:0] a,
                          input logic [OP_W-1:0] b);
      req_a[r*OP_W +: OP_W] = a;
      req_b[r*OP_W +: OP_W] = b;
   endtask

   task automatic wait_rsp(output int n);
      n = 0;
      while (rsp_valid == '0 && n < 60) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (req_ready == '0 && n < 20) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      req_valid = 2'b11;
      repeat (2) @(negedge clk);
      tests++;
      if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_ctl: ready=%b valid=%b busy=%b want 00 00 0",
                  req_ready, rsp_valid, busy);
      end
      tests++;
      if (rsp_data !== '0 || rsp_err !== 1'b0 || mul_start !== 1'b0 ||
          mul_a !== '0 || mul_b !== '0 || grant_id !== 3'd0) begin
         fails++;
         $display("FAIL reset_data: data=%h err=%b start=%b gid=%0d want 0",
                  rsp_data[15:0], rsp_err, mul_start, grant_id);
      end
      req_valid = 2'b00;
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single;
      int n;
      int starts;
      int busy_low;
      set_ops(0, 284'h1, 284'h3);
      req_valid = 2'b01;
      #1;
      tests++;
      if (req_ready !== 2'b01) begin
         fails++;
         $display("FAIL single_ready: got %b want 01", req_ready);
      end
      n = 0;
      starts = 0;
      busy_low = 0;
      do begin
         @(negedge clk);
         n++;
         if (mul_start) starts++;
         if (!busy) busy_low++;
         if (n == 1) begin
            req_valid = 2'b00;
            tests++;
            if (mul_start !== 1'b1 || mul_a !== 284'h1 || mul_b !== 284'h3) begin
               fails++;
               $display("FAIL single_issue: start=%b a=%h b=%h want 1 1 3",
                        mul_start, mul_a[7:0], mul_b[7:0]);
            end
         end
      end while (rsp_valid == '0 && n < 40);
      tests++;
      if (n != 8 || rsp_valid !== 2'b01 || rsp_data !== 568'h3) begin
         fails++;
         $display("FAIL single_rsp: at T+%0d valid=%b data=%h want T+8 01 3",
                  n, rsp_valid, rsp_data[15:0]);
      end
      tests++;
      if (starts != 1 || busy_low != 0) begin
         fails++;
         $display("FAIL single_pulse: starts=%0d busy_low=%0d want 1 0",
                  starts, busy_low);
      end
      rsp_ready = 2'b01;
      @(negedge clk);
      rsp_ready = 2'b00;
      tests++;
      if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
         fails++;
         $display("FAIL single_done: valid=%b busy=%b want 00 0",
                  rsp_valid, busy);
      end
   endtask

   task automatic test_round_robin;
      int n;
      logic [1:0] exp;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      set_ops(0, 284'h5, 284'h7);
      set_ops(1, 284'h5, 284'h7);
      rsp_ready = 2'b11;
      req_valid = 2'b11;
      #1;
      for (int j = 0; j < 4; j++) begin
         exp = (j % 2 == 0) ? 2'b01 : 2'b10;
         wait_ready(n);
         tests++;
         if (req_ready !== exp) begin
            fails++;
            $display("FAIL rr_grant%0d: ready=%b want %b", j, req_ready, exp);
         end
         @(negedge clk);
         wait_rsp(n);
         tests++;
         if (rsp_valid !== exp || rsp_data !== 568'h1B ||
             grant_id !== 3'(j % 2)) begin
            fails++;
            $display("FAIL rr_rsp%0d: valid=%b data=%h gid=%0d want %b 1b %0d",
                     j, rsp_valid, rsp_data[15:0], grant_id, exp, j % 2);
         end
         @(negedge clk);
      end
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      int n;
      int starts;
      set_ops(0, 284'h1, 284'h3);
      set_ops(1, 284'h2, 284'h2);
      req_valid = 2'b11;
      #1;
      wait_ready(n);
      tests++;
      if (req_ready !== 2'b01) begin
         fails++;
         $display("FAIL bp_grant: ready=%b want 01", req_ready);
      end
      @(negedge clk);
      wait_rsp(n);
      starts = 0;
      for (int c = 0; c < 10; c++) begin
         tests++;
         if (rsp_valid !== 2'b01 || rsp_data !== 568'h3 ||
             req_ready !== 2'b00 || mul_start !== 1'b0) begin
            fails++;
            $display("FAIL bp_hold%0d: valid=%b data=%h ready=%b start=%b",
                     c, rsp_valid, rsp_data[15:0], req_ready, mul_start);
         end
         @(negedge clk);
      end
      rsp_ready = 2'b01;
      @(negedge clk);
      rsp_ready = 2'b00;
      tests++;
      if (req_ready !== 2'b10) begin
         fails++;
         $display("FAIL bp_next: ready=%b want 10", req_ready);
      end
      req_valid = 2'b00;
      @(negedge clk);
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL bp_withdraw: busy=%b want 0", busy);
      end
   endtask

   task automatic test_spurious;
      int n;
      spur = 1'b1;
      @(negedge clk);
      spur = 1'b0;
      @(negedge clk);
      tests++;
      if (busy !== 1'b0 || rsp_valid !== 2'b00 || rsp_data !== 568'h3) begin
         fails++;
         $display("FAIL spur_idle: busy=%b valid=%b data=%h want 0 00 3",
                  busy, rsp_valid, rsp_data[15:0]);
      end
      set_ops(0, 284'h6, 284'h3);
      req_valid = 2'b01;
      @(negedge clk);
      req_valid = 2'b00;
      wait_rsp(n);
      tests++;
      if (rsp_valid !== 2'b01 || rsp_data !== 568'hA) begin
         fails++;
         $display("FAIL spur_job: valid=%b data=%h want 01 a",
                  rsp_valid, rsp_data[15:0]);
      end
      spur = 1'b1;
      @(negedge clk);
      spur = 1'b0;
      @(negedge clk);
      tests++;
      if (rsp_valid !== 2'b01 || rsp_data !== 568'hA || busy !== 1'b1) begin
         fails++;
         $display("FAIL spur_resp: valid=%b data=%h busy=%b want 01 a 1",
                  rsp_valid, rsp_data[15:0], busy);
      end
      rsp_ready = 2'b01;
      @(negedge clk);
      rsp_ready = 2'b00;
   endtask

   task automatic test_reset_mid_wait;
      int n;
      int seen;
      set_ops(1, 284'h3, 284'h3);
      req_valid = 2'b10;
      @(negedge clk);
      req_valid = 2'b00;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      tests++;
      if (busy !== 1'b0 || rsp_valid !== 2'b00 || mul_a !== '0 ||
          mul_b !== '0 || grant_id !== 3'd0 || rsp_data !== '0 ||
          mul_start !== 1'b0 || req_ready !== 2'b00) begin
         fails++;
         $display("FAIL rst_wait: busy=%b valid=%b a=%h gid=%0d data=%h",
                  busy, rsp_valid, mul_a[7:0], grant_id, rsp_data[15:0]);
      end
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (rsp_valid != '0 || busy) seen++;
      end
      tests++;
      if (seen != 0) begin
         fails++;
         $display("FAIL rst_late_done: active cycles=%0d want 0", seen);
      end
      set_ops(0, 284'h1, 284'h3);
      req_valid = 2'b11;
      #1;
      tests++;
      if (req_ready !== 2'b01) begin
         fails++;
         $display("FAIL rst_regrant: ready=%b want 01", req_ready);
      end
      @(negedge clk);
      req_valid = 2'b00;
      wait_rsp(n);
      tests++;
      if (rsp_valid !== 2'b01 || rsp_data !== 568'h3) begin
         fails++;
         $display("FAIL rst_job: valid=%b data=%h want 01 3",
                  rsp_valid, rsp_data[15:0]);
      end
      rsp_ready = 2'b01;
      @(negedge clk);
      rsp_ready = 2'b00;
   endtask

`ifdef GF2ARB_TIMEOUT_EN
   task automatic test_timeout;
      int n;
      model_en = 1'b0;
      set_ops(0, 284'h1, 284'h3);
      req_valid = 2'b01;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) req_valid = 2'b00;
      end while (rsp_valid == '0 && n < 60);
      tests++;
      if (n != 18 || rsp_err !== 1'b1 || rsp_data !== '0) begin
         fails++;
         $display("FAIL timeout_rsp: at T+%0d err=%b data=%h want T+18 1 0",
                  n, rsp_err, rsp_data[15:0]);
      end
      rsp_ready = 2'b01;
      @(negedge clk);
      rsp_ready = 2'b00;
      tests++;
      if (rsp_err !== 1'b0 || rsp_valid !== 2'b00) begin
         fails++;
         $display("FAIL timeout_clear: err=%b valid=%b want 0 00",
                  rsp_err, rsp_valid);
      end
      model_en = 1'b1;
   endtask
`endif

   initial begin
      reset      = 1'b1;
      req_valid  = '0;
      rsp_ready  = '0;
      req_a      = '0;
      req_b      = '0;
      spur       = 1'b0;
      model_en   = 1'b1;
      model_done = 1'b0;
      mcnt       = '0;
      mul_w      = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_spurious();
      test_reset_mid_wait();
`ifdef GF2ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
